omni_distributor: RTL and testbench
===================================

# omni_distributor

Fan-out counterpart of the omni collector in the top-k kernel. It accepts one AXI-Stream-style beat stream of `WIDTH` bits, each beat carrying a `TAG_WIDTH` routing tag in its MSBs. It steers every beat to one of `NUM_SLOTS + 1` output ports: slots `0..NUM_SLOTS-1` are worker slots, and slot `NUM_SLOTS` is loopback. Each output has a 2-entry buffer, so a stalled slot blocks the input only when that slot is the current target.

## Interface
- `NUM_SLOTS`, default 2: number of worker slots; total outputs = `NUM_SLOTS + 1`.
- `WIDTH`, default 512+16: beat width, tag included.
- `TAG_WIDTH`, default 16: routing tag width; the tag is `in_TDATA[WIDTH-1 -: TAG_WIDTH]`.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_TDATA`  in  `WIDTH`  input beat.
- `in_TVALID`  in  1  input valid.
- `in_TREADY`  out  1  input ready.
- `out_TDATA`  out  `(NUM_SLOTS+1)*WIDTH`  slot k at bits `[(k+1)*WIDTH-1 -: WIDTH]`.
- `out_TVALID`  out  `NUM_SLOTS+1`  per-slot valid.
- `out_TREADY`  in  `NUM_SLOTS+1`  per-slot ready.

## Operation
- Target slot selection:
  - `tgt = tag` if `tag < NUM_SLOTS`.
  - `tgt = NUM_SLOTS` (loopback) otherwise.
  - The comparison uses the full `TAG_WIDTH`-bit tag, so large tags never alias onto a worker slot.
- The beat is forwarded unmodified, tag bits included.
- Each slot k owns a 2-entry FIFO:
  - `cnt[k]` ranges 0..2.
  - `rd_ptr[k]` and `wr_ptr[k]` are 1-bit pointers that wrap 1→0.
- `in_TREADY = !rst && (cnt[tgt] != 2)`.
  - It depends only on `in_TDATA` tag and registered state, never on `out_TREADY`.
  - A full slot that is popping in the same cycle still refuses the push.
- Push: when `in_TVALID && in_TREADY`, write the beat at `wr_ptr[tgt]` and increment `wr_ptr[tgt]`.
- Pop: when `out_TVALID[k] && out_TREADY[k]`, increment `rd_ptr[k]`.
- Count update, per slot:
  - push only: `cnt` +1.
  - pop only: `cnt` −1.
  - push and pop together (possible only when cnt = 1): `cnt` unchanged.
- `out_TVALID[k] = (cnt[k] != 0)`; `out_TDATA` slot k = entry at `rd_ptr[k]`.
- Ordering:
  - Beats for the same slot leave in arrival order.
  - No ordering guarantee across slots.
- Non-target slots drain independently of input stalls.
- AXI rule: once `out_TVALID[k]` is asserted, it and `out_TDATA` slot k stay stable until accepted. The FIFO head guarantees this.
- An input beat with `in_TVALID = 0` has no effect regardless of tag.

## Timing
- Reset (`rst` high at a clock edge):
  - `cnt`, `rd_ptr` and `wr_ptr` of all slots are cleared.
  - `out_TVALID` = 0 and `in_TREADY` = 0 from the next cycle while `rst` is held.
  - `out_TDATA` is don't-care but is also cleared to 0.
  - Buffered beats are discarded.
  - Reset asserted mid-burst aborts it; no partial state survives.
- Latency: a beat accepted at edge t appears on `out_TVALID[tgt]` after edge t, i.e. 1 cycle.
- Throughput: 1 beat/cycle into a slot whose consumer holds `out_TREADY` high, because cnt alternates 0→1→0 or stays at 1 with simultaneous push/pop.
- Full: with `out_TREADY[k]` = 0, exactly 2 beats are accepted for slot k; the third stalls.
- Empty: `out_TVALID[k]` drops in the cycle after the last pop.

## Structure
- Shared package/header `omni_pkg` holds:
  - default `WIDTH` (528) and `TAG_WIDTH` (16);
  - the tag-position constant;
  - `LOOPBACK_SLOT = NUM_SLOTS` as a convention, shared with the collector.
- Sub-module `omni_slot_fifo`: parameter `WIDTH`; 2-entry FIFO with push/pop handshake, `full` and `empty`, plus head data.
  - The top instantiates it `NUM_SLOTS+1` times in a generate loop.
  - The top contains only the tag decode and the push-enable one-hot.

## Test plan
- Reset, then one beat with tag 1 and payload `0xA5…`, `out_TREADY` all 1 → `out_TVALID = 3'b010` one cycle later with identical data; no other slot is valid.
- Tags 0, 5 and `0xFFFF` with `NUM_SLOTS` = 2 → beats appear on slots 0, 2 and 2 respectively (loopback).
- `out_TREADY[0]` = 0, stream of 4 tag-0 beats → `in_TREADY` goes 1, 1, 0. Then raise `out_TREADY[0]` → beats exit in order 1, 2, 3, 4 and cnt returns to 0.
- Slot 0 full and blocked, next beat tag 1 → `in_TREADY` = 1 and the beat is delivered to slot 1 while slot 0 keeps holding stable valid data.
- Continuous tag-2 stream with `out_TREADY[2]` = 1 → 1 beat/cycle sustained for 100 beats, with no bubble after the first cycle.
- Assert `rst` for 1 cycle while slots 0 and 1 each hold 2 beats → all `out_TVALID` = 0 after the edge. A subsequent tag-1 beat emerges alone, and none of the stale beats appear.

Source files
------------

// File: rtl/omni_pkg.sv
// Shared constants for the omni collector/distributor pair: default beat
// geometry, where the routing tag sits in a beat, and the loopback slot index.
package omni_pkg;

  localparam int OMNI_WIDTH     = 512 + 16;
  localparam int OMNI_TAG_WIDTH = 16;

  // The routing tag occupies the most significant bits of every beat.
  function automatic int tag_msb(input int width);
    return width - 1;
  endfunction

  // Loopback is always the port just past the last worker slot.
  function automatic int loopback_slot(input int num_slots);
    return num_slots;
  endfunction

endpackage

// File: rtl/omni_distributor_if.sv
// Stream bundle between the distributor and its neighbours: one input stream
// and NUM_SLOTS+1 flattened output streams.
interface omni_distributor_if #(
  parameter int NUM_SLOTS = 2,
  parameter int WIDTH     = omni_pkg::OMNI_WIDTH
);
  logic [WIDTH-1:0]               in_TDATA;
  logic                           in_TVALID;
  logic                           in_TREADY;
  logic [(NUM_SLOTS+1)*WIDTH-1:0] out_TDATA;
  logic [NUM_SLOTS:0]             out_TVALID;
  logic [NUM_SLOTS:0]             out_TREADY;

  // Distributor side: consumes the input stream, produces the slot streams.
  modport slave (
    input  in_TDATA, in_TVALID, out_TREADY,
    output in_TREADY, out_TDATA, out_TVALID
  );

  // Environment side: produces the input stream, consumes the slot streams.
  modport master (
    output in_TDATA, in_TVALID, out_TREADY,
    input  in_TREADY, out_TDATA, out_TVALID
  );
endinterface

// File: rtl/omni_slot_fifo.sv
// Two-entry FIFO for one output slot. The head entry stays put until popped,
// which keeps the slot's valid/data stable while the consumer stalls.
module omni_slot_fifo
  import omni_pkg::*;
#(
  parameter int WIDTH = OMNI_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy; reset wipes buffered beats as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/omni_distributor.sv
// Tag-routed fan-out: each input beat goes to the worker slot named by its tag,
// or to the loopback slot when the tag is out of range. Every slot has its own
// two-entry buffer, so only the currently targeted slot can stall the input.
module omni_distributor
  import omni_pkg::*;
#(
  parameter int NUM_SLOTS = 2,
  parameter int WIDTH     = OMNI_WIDTH,
  parameter int TAG_WIDTH = OMNI_TAG_WIDTH
) (
  input logic                clk,
  input logic                rst,
  omni_distributor_if.slave  bus
);

  localparam int NUM_OUT = NUM_SLOTS + 1;
  localparam int SLOT_W  = $clog2(NUM_OUT);
  localparam int TAG_MSB = tag_msb(WIDTH);

  logic [TAG_WIDTH-1:0] w_tag;
  logic [SLOT_W-1:0]    w_tgt;
  logic                 w_tgt_full;
  logic                 w_in_ready;
  logic [NUM_SLOTS:0]   w_push;
  logic [NUM_SLOTS:0]   w_pop;
  logic [NUM_SLOTS:0]   w_full;
  logic [NUM_SLOTS:0]   w_empty;

  assign w_tag = bus.in_TDATA[TAG_MSB -: TAG_WIDTH];

  // Full-width comparison so large tags can never alias onto a worker slot.
  always_comb begin
    w_tgt = SLOT_W'(loopback_slot(NUM_SLOTS));
    if (w_tag < TAG_WIDTH'(NUM_SLOTS)) begin
      w_tgt = SLOT_W'(w_tag);
    end
  end

  // Ready follows only the target slot's occupancy, never the output readies.
  always_comb begin
    w_tgt_full = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (w_tgt == SLOT_W'(k)) begin
        w_tgt_full = w_full[k];
      end
    end
  end

  assign w_in_ready    = !rst && !w_tgt_full;
  assign bus.in_TREADY = w_in_ready;

  // One-hot push enable toward the target slot.
  always_comb begin
    w_push = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      w_push[k] = bus.in_TVALID && w_in_ready && (w_tgt == SLOT_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    assign w_pop[g]          = !w_empty[g] && bus.out_TREADY[g];
    assign bus.out_TVALID[g] = !w_empty[g];

    omni_slot_fifo #(
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_data  (bus.in_TDATA),
      .i_pop   (w_pop[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_head  (bus.out_TDATA[(g+1)*WIDTH-1 -: WIDTH])
    );
  end

endmodule

// File: tb/tb_omni_distributor.sv
// Directed bench for omni_distributor with NUM_SLOTS = 2 (slots 0,1 + loopback 2).
module tb_omni_distributor;
  import omni_pkg::*;

  localparam int NS = 2;
  localparam int W  = OMNI_WIDTH;
  localparam int TW = OMNI_TAG_WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  omni_distributor_if #(.NUM_SLOTS(NS), .WIDTH(W)) bus ();

  omni_distributor #(.NUM_SLOTS(NS), .WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [W-1:0] mk(input logic [TW-1:0] tag, input logic [31:0] word);
    return {tag, {16{word}}};
  endfunction

  function automatic logic [W-1:0] slot_data(input int k);
    return bus.out_TDATA[(k+1)*W-1 -: W];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] b [4];
  logic [W-1:0] beat;
  logic [TW-1:0] tags [3];
  int            exp_slot [3];

  initial begin
    rst            = 1'b1;
    bus.in_TDATA   = '0;
    bus.in_TVALID  = 1'b0;
    bus.out_TREADY = '0;
    step();
    step();
    chk("rst_out_valid", W'(bus.out_TVALID), W'(3'b000));
    chk("rst_in_ready", W'(bus.in_TREADY), W'(1'b0));
    chk("rst_data0", slot_data(0), '0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", W'(bus.in_TREADY), W'(1'b1));

    // Single tag-1 beat
    bus.out_TREADY = 3'b111;
    beat = mk(16'd1, 32'hA5A5A5A5);
    bus.in_TDATA  = beat;
    bus.in_TVALID = 1'b1;
    #1;
    chk("t1_in_ready", W'(bus.in_TREADY), W'(1'b1));
    step();
    bus.in_TVALID = 1'b0;
    chk("t1_out_valid", W'(bus.out_TVALID), W'(3'b010));
    chk("t1_data", slot_data(1), beat);
    step();
    chk("t1_drained", W'(bus.out_TVALID), W'(3'b000));

    // Tag decode: 0 -> slot 0, 5 -> loopback, 0xFFFF -> loopback
    tags[0] = 16'd0;    exp_slot[0] = 0;
    tags[1] = 16'd5;    exp_slot[1] = 2;
    tags[2] = 16'hFFFF; exp_slot[2] = 2;
    for (int i = 0; i < 3; i++) begin
      beat = mk(tags[i], 32'h1000 + i);
      bus.in_TDATA  = beat;
      bus.in_TVALID = 1'b1;
      step();
      bus.in_TVALID = 1'b0;
      chk($sformatf("dec%0d_valid", i), W'(bus.out_TVALID), W'(3'b001 << exp_slot[i]));
      chk($sformatf("dec%0d_data", i), slot_data(exp_slot[i]), beat);
      step();
    end

    // Slot 0 blocked: two beats accepted, third stalls
    for (int i = 0; i < 4; i++) b[i] = mk(16'd0, 32'hB0 + i + 1);
    bus.out_TREADY = 3'b110;
    bus.in_TDATA   = b[0];
    bus.in_TVALID  = 1'b1;
    #1;
    chk("full_rdy1", W'(bus.in_TREADY), W'(1'b1));
    step();
    chk("full_head1", slot_data(0), b[0]);
    bus.in_TDATA = b[1];
    #1;
    chk("full_rdy2", W'(bus.in_TREADY), W'(1'b1));
    step();
    bus.in_TDATA = b[2];
    #1;
    chk("full_rdy3", W'(bus.in_TREADY), W'(1'b0));
    step();
    chk("full_stall_rdy", W'(bus.in_TREADY), W'(1'b0));
    chk("full_stable", slot_data(0), b[0]);

    // Other slot still flows while slot 0 is full
    beat = mk(16'd1, 32'hC0C0C0C0);
    bus.in_TDATA = beat;
    #1;
    chk("bypass_rdy", W'(bus.in_TREADY), W'(1'b1));
    step();
    bus.in_TVALID = 1'b0;
    chk("bypass_valid", W'(bus.out_TVALID), W'(3'b011));
    chk("bypass_data1", slot_data(1), beat);
    chk("bypass_hold0", slot_data(0), b[0]);
    step();
    chk("bypass_drain", W'(bus.out_TVALID), W'(3'b001));

    // Release slot 0: full slot popping still refuses the push
    bus.in_TDATA   = b[2];
    bus.in_TVALID  = 1'b1;
    bus.out_TREADY = 3'b111;
    #1;
    chk("pop_full_rdy", W'(bus.in_TREADY), W'(1'b0));
    step();
    chk("order_b2", slot_data(0), b[1]);
    chk("after_pop_rdy", W'(bus.in_TREADY), W'(1'b1));
    step();
    chk("order_b3", slot_data(0), b[2]);
    bus.in_TDATA = b[3];
    step();
    bus.in_TVALID = 1'b0;
    chk("order_b4", slot_data(0), b[3]);
    chk("order_b4_valid", W'(bus.out_TVALID), W'(3'b001));
    step();
    chk("order_empty", W'(bus.out_TVALID), W'(3'b000));

    // Sustained loopback stream, one beat per cycle
    bus.in_TDATA  = mk(16'd2, 32'd0);
    bus.in_TVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      chk($sformatf("strm%0d_rdy", i), W'(bus.in_TREADY), W'(1'b1));
      step();
      chk($sformatf("strm%0d_data", i), slot_data(2), mk(16'd2, 32'(i)));
      chk($sformatf("strm%0d_valid", i), W'(bus.out_TVALID), W'(3'b100));
      if (i < 99) bus.in_TDATA = mk(16'd2, 32'(i + 1));
      else        bus.in_TVALID = 1'b0;
    end
    step();
    chk("strm_drain", W'(bus.out_TVALID), W'(3'b000));

    // Reset mid-traffic discards buffered beats
    bus.out_TREADY = 3'b000;
    for (int i = 0; i < 4; i++) begin
      bus.in_TDATA  = mk(TW'(i / 2), 32'hD0 + i);
      bus.in_TVALID = 1'b1;
      step();
    end
    bus.in_TVALID = 1'b0;
    chk("pre_rst_valid", W'(bus.out_TVALID), W'(3'b011));
    rst = 1'b1;
    step();
    chk("mid_rst_valid", W'(bus.out_TVALID), W'(3'b000));
    chk("mid_rst_rdy", W'(bus.in_TREADY), W'(1'b0));
    rst = 1'b0;
    bus.out_TREADY = 3'b111;
    beat = mk(16'd1, 32'hE1E1E1E1);
    bus.in_TDATA  = beat;
    bus.in_TVALID = 1'b1;
    step();
    bus.in_TVALID = 1'b0;
    chk("post_rst_valid", W'(bus.out_TVALID), W'(3'b010));
    chk("post_rst_data", slot_data(1), beat);
    step();
    chk("post_rst_empty", W'(bus.out_TVALID), W'(3'b000));
    chk("post_rst_slot0", slot_data(0), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
